sst_sequencer: RTL and testbench
================================

Name: sst_sequencer

Overview:
- Save-state sequencer directly upstream of every mapper's SSTBus input.
- Walks mapper register addresses and drives sst.act, sst.addr, sst.we_reg and sst.dato.
- On save, captures the mapper's sst_di into a state buffer memory; on load, replays stored bytes into the mapper.
- Sits between the system state-buffer memory port and the mapper's MapIn.sst / MapOut.sst_di.

Parameters:
- REG_COUNT, 128: number of register slots walked (addresses 0..REG_COUNT-1; slot 127 returns map_idx).
- SETTLE_CYC, 2: clk cycles sst_addr is held before sst_di is sampled (save).
- HOLD_CYC, 32: clk cycles sst_we_reg/sst_dato are held; must exceed one full M2 period so a negedge cpu.m2 falls inside.
- MEM_BASE, 0: 16-bit base address of the state buffer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_save  in  1  one-cycle request: save mapper state
- start_load  in  1  one-cycle request: load mapper state
- busy  out  1  high while a sequence runs
- done  out  1  one-cycle pulse at sequence end
- sst_act  out  1  to SSTBus.act
- sst_addr  out  8  to SSTBus.addr
- sst_we_reg  out  1  to SSTBus.we_reg
- sst_dato  out  8  to SSTBus.dato
- sst_di  in  8  from MapOut.sst_di
- mem_req  out  1  buffer request, held until mem_ack
- mem_we  out  1  1=write, 0=read, valid with mem_req
- mem_addr  out  16  MEM_BASE + slot index
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle completion

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Reset mid-sequence drops sst_act and mem_req in the same cycle.
  - No done pulse is issued after reset.
- States: IDLE, SETUP, SETTLE, MEMREQ, HOLD, GAP, NEXT, FIN.
- IDLE:
  - start_save or start_load moves to SETUP; slot=0; mode is latched.
  - If both are high in the same cycle, save wins.
  - Starts while busy=1 are ignored.
- busy and sst_act rise in the first cycle of SETUP and fall when FIN exits.
- sst_addr = slot throughout; it changes only in NEXT.
- Save path: SETUP → SETTLE (SETTLE_CYC cycles) → sample sst_di into mem_wdata → MEMREQ with mem_we=1, held until mem_ack → NEXT.
- Load path:
  - SETUP → MEMREQ with mem_we=0; in the mem_ack cycle, latch mem_rdata into sst_dato.
  - HOLD: sst_we_reg=1 for exactly HOLD_CYC cycles, with sst_dato stable.
  - GAP: 1 cycle with sst_we_reg=0.
  - Then NEXT.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from request until mem_ack. mem_ack outside MEMREQ is ignored.
- NEXT:
  - If slot==REG_COUNT-1 → FIN; otherwise slot+1 → SETUP.
  - slot is 8 bits; REG_COUNT ≤ 256, so there is no wrap.
- FIN: done=1 for one cycle, then IDLE.
- The load path still drives slot 127 (map_idx); the mapper ignores it.
- sst_we_reg is never 1 during a save.

Optional Feature:
- Macro: SST_CHECKSUM_EN.
- When defined:
  - Adds output sum_err (1 bit) and reserves buffer slot REG_COUNT (mem_addr = MEM_BASE+REG_COUNT) for a checksum.
  - The checksum is an 8-bit modular sum of all slot bytes.
  - Save: after the last slot, one extra MEMREQ write of the sum, before FIN.
  - Load: accumulates the read bytes, then reads the extra slot before FIN. sum_err=1 on mismatch.
  - sum_err is cleared at the next start; reset value 0. Register writes are not suppressed on mismatch.
- When undefined: no sum_err port and no extra memory access.

Test Plan:
- Save, model sst_di = addr^8'h5A, mem_ack 3 cycles after req → 128 writes, mem_addr 0..127, data = addr^8'h5A; done pulses once; sst_we_reg never 1.
- Load, mem_rdata = 8'hA0+addr → each slot holds sst_we_reg high exactly 32 cycles with sst_dato = 8'hA0+addr; slot 0 mapper model captures 8'hA0 on negedge M2 (M2 period 28 clk).
- start_save and start_load in the same cycle → save sequence only; start_load while busy → ignored; exactly one done pulse.
- rst asserted during a load HOLD at slot 40 → next cycle sst_act=0, sst_we_reg=0, mem_req=0, busy=0; no done pulse.
- mem_ack withheld 100 cycles → mem_req and mem_addr stable, FSM stalls, sst_addr unchanged.
- SST_CHECKSUM_EN: save, then load with slot 10 corrupted by +1 → 129 accesses each way; sum_err=1 at done; clean reload → sum_err=0.

Source files
------------

// File: rtl/sst_sequencer_if.sv
// Save-state sequencer bus bundle: SSTBus drive/return plus the state-buffer memory port.
// The sequencer uses the master view; the mapper/memory side uses the slave view.
interface sst_sequencer_if;
  logic        sst_act;
  logic [7:0]  sst_addr;
  logic        sst_we_reg;
  logic [7:0]  sst_dato;
  logic [7:0]  sst_di;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output sst_act, sst_addr, sst_we_reg, sst_dato,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  sst_di, mem_rdata, mem_ack
  );

  modport slave (
    input  sst_act, sst_addr, sst_we_reg, sst_dato,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output sst_di, mem_rdata, mem_ack
  );
endinterface

// File: rtl/sst_sequencer.sv
// Save-state sequencer: walks mapper register slots, saving sst_di to the state buffer or
// replaying buffered bytes into the mapper. Optional checksum slot under SST_CHECKSUM_EN.
module sst_sequencer #(
  parameter int unsigned REG_COUNT  = 128,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 32,
  parameter logic [15:0] MEM_BASE   = 16'h0000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_save,
  input  logic           start_load,
  output logic           busy,
`ifdef SST_CHECKSUM_EN
  output logic           sum_err,
`endif
  output logic           done,
  sst_sequencer_if.master bus
);

  localparam logic [7:0]  LastSlot   = 8'(REG_COUNT - 1);
  localparam logic [15:0] SettleLast = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] HoldLast   = 16'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSettle,
    StMemReq,
    StHold,
    StGap,
    StNext,
    StFin
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  slot_q, slot_d;
  logic [15:0] cnt_q, cnt_d;
  logic        save_q, save_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  dato_q, dato_d;
`ifdef SST_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic        sum_phase_q, sum_phase_d;
  logic        sum_err_q, sum_err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      slot_q      <= 8'h00;
      cnt_q       <= 16'h0000;
      save_q      <= 1'b0;
      wdata_q     <= 8'h00;
      dato_q      <= 8'h00;
`ifdef SST_CHECKSUM_EN
      sum_q       <= 8'h00;
      sum_phase_q <= 1'b0;
      sum_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      save_q      <= save_d;
      wdata_q     <= wdata_d;
      dato_q      <= dato_d;
`ifdef SST_CHECKSUM_EN
      sum_q       <= sum_d;
      sum_phase_q <= sum_phase_d;
      sum_err_q   <= sum_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    cnt_d       = cnt_q;
    save_d      = save_q;
    wdata_d     = wdata_q;
    dato_d      = dato_q;
`ifdef SST_CHECKSUM_EN
    sum_d       = sum_q;
    sum_phase_d = sum_phase_q;
    sum_err_d   = sum_err_q;
`endif

    case (state_q)
      StIdle: begin
        if (start_save || start_load) begin
          state_d = StSetup;
          slot_d  = 8'h00;
          save_d  = start_save;  // save has priority on a simultaneous request
`ifdef SST_CHECKSUM_EN
          sum_d       = 8'h00;
          sum_phase_d = 1'b0;
          sum_err_d   = 1'b0;
`endif
        end
      end

      StSetup: begin
        cnt_d   = 16'h0000;
        state_d = save_q ? StSettle : StMemReq;
      end

      StSettle: begin
        if (cnt_q == SettleLast) begin
          wdata_d = bus.sst_di;
`ifdef SST_CHECKSUM_EN
          sum_d   = sum_q + bus.sst_di;
`endif
          state_d = StMemReq;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StMemReq: begin
        if (bus.mem_ack) begin
`ifdef SST_CHECKSUM_EN
          if (sum_phase_q) begin
            if (!save_q) begin
              sum_err_d = (bus.mem_rdata != sum_q);
            end
            state_d = StFin;
          end else if (save_q) begin
            state_d = StNext;
          end else begin
            dato_d  = bus.mem_rdata;
            sum_d   = sum_q + bus.mem_rdata;
            cnt_d   = 16'h0000;
            state_d = StHold;
          end
`else
          if (save_q) begin
            state_d = StNext;
          end else begin
            dato_d  = bus.mem_rdata;
            cnt_d   = 16'h0000;
            state_d = StHold;
          end
`endif
        end
      end

      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StGap: begin
        state_d = StNext;
      end

      StNext: begin
        if (slot_q == LastSlot) begin
`ifdef SST_CHECKSUM_EN
          // One extra buffer access for the checksum slot before finishing.
          sum_phase_d = 1'b1;
          wdata_d     = sum_q;
          state_d     = StMemReq;
`else
          state_d = StFin;
`endif
        end else begin
          slot_d  = slot_q + 8'd1;
          state_d = StSetup;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy           = (state_q != StIdle);
    done           = (state_q == StFin);
    bus.sst_act    = (state_q != StIdle);
    bus.sst_addr   = slot_q;
    bus.sst_we_reg = (state_q == StHold);
    bus.sst_dato   = dato_q;
    bus.mem_req    = (state_q == StMemReq);
    bus.mem_we     = (state_q == StMemReq) && save_q;
    bus.mem_addr   = 16'h0000;
    bus.mem_wdata  = 8'h00;
    if (state_q == StMemReq) begin
`ifdef SST_CHECKSUM_EN
      bus.mem_addr = sum_phase_q ? (MEM_BASE + 16'(REG_COUNT)) : (MEM_BASE + {8'h00, slot_q});
`else
      bus.mem_addr = MEM_BASE + {8'h00, slot_q};
`endif
      if (save_q) begin
        bus.mem_wdata = wdata_q;
      end
    end
`ifdef SST_CHECKSUM_EN
    sum_err = sum_err_q;
`endif
  end

endmodule

// File: tb/tb_sst_sequencer.sv
// Self-checking bench for sst_sequencer: memory/mapper models, transaction scoreboard,
// per-cycle protocol checks and directed scenarios (save, load, stall, reset, checksum).
module tb_sst_sequencer;

  localparam int          REG_COUNT  = 128;
  localparam int          SETTLE_CYC = 2;
  localparam int          HOLD_CYC   = 32;
  localparam logic [15:0] MEM_BASE   = 16'h0000;
`ifdef SST_CHECKSUM_EN
  localparam int          NTX = REG_COUNT + 1;
`else
  localparam int          NTX = REG_COUNT;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_save = 1'b0;
  logic start_load = 1'b0;
  logic busy;
  logic done;
`ifdef SST_CHECKSUM_EN
  logic sum_err;
`endif

  sst_sequencer_if bus ();

  sst_sequencer #(
    .REG_COUNT  (REG_COUNT),
    .SETTLE_CYC (SETTLE_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .MEM_BASE   (MEM_BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_save (start_save),
    .start_load (start_load),
    .busy       (busy),
`ifdef SST_CHECKSUM_EN
    .sum_err    (sum_err),
`endif
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Models and scoreboard state
  logic [7:0] mem [0:255];
  logic [7:0] mapreg [0:255];
  bit         mapwr [0:255];
  logic [7:0] key = 8'h5A;
  int         ack_delay = 3;    // 0 selects a random delay per request
  int         stall_addr = -1;
  bit         chk_en = 1'b0;
  bit         exp_save = 1'b0;
  int         exp_idx = 0;
  int         done_cnt = 0;

  function automatic logic [7:0] exp_wdata(input int idx);
    logic [7:0] s;
    s = 8'h00;
    if (idx < REG_COUNT) return 8'(idx) ^ key;
    for (int a = 0; a < REG_COUNT; a++) s = s + (8'(a) ^ key);
    return s;
  endfunction

  function automatic bit exp_sum_mismatch();
    logic [7:0] s;
    s = 8'h00;
    for (int a = 0; a < REG_COUNT; a++) s = s + mem[a];
    return s != mem[REG_COUNT];
  endfunction

  // State-buffer memory: acks after a programmable number of request cycles.
  initial begin
    int wait_cnt;
    int cur_delay;
    wait_cnt = 0;
    cur_delay = 1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst || bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'($urandom);
        wait_cnt = 0;
      end else if (bus.mem_req) begin
        wait_cnt++;
        if (wait_cnt == 1) begin
          cur_delay = (ack_delay == 0) ? int'($urandom_range(1, 6)) : ack_delay;
          if (int'(bus.mem_addr) == stall_addr) cur_delay = 101;
        end
        if (wait_cnt >= cur_delay) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
          if (bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr[7:0]];
        end else begin
          bus.mem_rdata = 8'($urandom);
        end
      end else begin
        wait_cnt = 0;
        bus.mem_rdata = 8'($urandom);
      end
    end
  end

  // Mapper read-back: sst_di only becomes valid two cycles after sst_addr changes.
  initial begin
    int age;
    logic [7:0] last;
    age = 10;
    last = 8'h00;
    bus.sst_di = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.sst_addr != last) age = 0;
      else age++;
      last = bus.sst_addr;
      bus.sst_di = (age >= 2) ? (bus.sst_addr ^ key) : 8'($urandom);
    end
  end

  // Compare process: mapper M2 capture, protocol invariants and transaction scoreboard.
  initial begin
    int m2_cnt, hold_len, hold_slot;
    logic [7:0] hold_dato, prev_addr, prev_wdata;
    logic [15:0] prev_maddr;
    logic prev_req, prev_ack, prev_we;
    m2_cnt = 0; hold_len = 0; hold_slot = 0; hold_dato = 0;
    prev_addr = 0; prev_wdata = 0; prev_maddr = 0;
    prev_req = 0; prev_ack = 0; prev_we = 0;
    forever begin
      @(negedge clk);
      m2_cnt = (m2_cnt + 1) % 28;
      if (m2_cnt == 14 && bus.sst_we_reg) begin
        mapreg[bus.sst_addr] = bus.sst_dato;
        mapwr[bus.sst_addr] = 1'b1;
      end
      if (done) done_cnt++;
      if (chk_en && !rst) begin
        check("act_vs_busy", bus.sst_act, busy);
        if (bus.sst_we_reg) check("we_reg_during_save", exp_save, 0);
        if (bus.sst_addr != prev_addr) check("sst_addr_step", bus.sst_addr, exp_idx);
        if (bus.mem_req && prev_req && !prev_ack) begin
          check("req_addr_stable", bus.mem_addr, prev_maddr);
          check("req_we_stable", bus.mem_we, prev_we);
          check("req_wdata_stable", bus.mem_wdata, prev_wdata);
          check("stall_sst_addr", bus.sst_addr, prev_addr);
        end
        if (bus.mem_req && bus.mem_ack) begin
          check("mem_addr", bus.mem_addr, MEM_BASE + 16'(exp_idx));
          check("mem_we", bus.mem_we, exp_save);
          if (exp_save) check("mem_wdata", bus.mem_wdata, exp_wdata(exp_idx));
          if (exp_idx < REG_COUNT) check("sst_addr_at_ack", bus.sst_addr, exp_idx);
          exp_idx++;
        end
        if (bus.sst_we_reg) begin
          if (hold_len == 0) begin
            hold_dato = bus.sst_dato;
            hold_slot = int'(bus.sst_addr);
          end else begin
            check("dato_stable", bus.sst_dato, hold_dato);
          end
          hold_len++;
        end else if (hold_len != 0) begin
          check("hold_len", hold_len, HOLD_CYC);
          check("hold_dato", hold_dato, mem[hold_slot]);
          check("hold_slot", hold_slot, exp_idx - 1);
          hold_len = 0;
        end
        if (done) check("txn_count_at_done", exp_idx, NTX);
      end else begin
        hold_len = 0;
      end
      prev_addr  = bus.sst_addr;
      prev_req   = bus.mem_req;
      prev_ack   = bus.mem_ack;
      prev_we    = bus.mem_we;
      prev_maddr = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
    end
  end

  task automatic run(input bit save, input bit both);
    int lat;
    bit exp_err;
    @(negedge clk);
    exp_save = save || both;
    exp_idx  = 0;
    done_cnt = 0;
    chk_en   = 1'b1;
    start_save = save || both;
    start_load = !save || both;
    @(negedge clk);
    start_save = 1'b0;
    start_load = 1'b0;
    #1;
    check("busy_in_setup", busy, 1);
    lat = 0;
    while (!bus.mem_req && lat < 200) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("first_req_latency", lat, exp_save ? 1 + SETTLE_CYC : 1);
    for (int i = 0; i < 30000 && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (5) @(negedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("idle_after_run", busy, 0);
    exp_err = exp_save ? 1'b0 : exp_sum_mismatch();
`ifdef SST_CHECKSUM_EN
    check("sum_err_model", sum_err, exp_err);
`endif
  endtask

  initial begin
    int d0;
    bit found;
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'h00;
      mapreg[a] = 8'h00;
      mapwr[a] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_act", bus.sst_act, 0);
    check("rst_addr", bus.sst_addr, 0);
    check("rst_we_reg", bus.sst_we_reg, 0);
    check("rst_dato", bus.sst_dato, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
`ifdef SST_CHECKSUM_EN
    check("rst_sum_err", sum_err, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Save with sst_di = addr ^ 5A, ack 3 cycles after request
    key = 8'h5A;
    ack_delay = 3;
    run(1'b1, 1'b0);
    check("save_mem0", mem[0], 8'h5A);
    check("save_mem127", mem[127], 8'h25);
`ifdef SST_CHECKSUM_EN
    check("save_sum_slot", mem[128], 8'hC0);
`endif

    // Load A0+addr; mapper model captures on negedge M2
    for (int a = 0; a < REG_COUNT; a++) begin
      mem[a] = 8'hA0 + 8'(a);
      mapwr[a] = 1'b0;
    end
    mem[REG_COUNT] = 8'hC0;
    run(1'b0, 1'b0);
    check("map_slot0", {7'h0, mapwr[0], mapreg[0]}, 16'h01A0);
    for (int a = 0; a < REG_COUNT; a++)
      check("map_slot", {7'h0, mapwr[a], mapreg[a]}, {8'h01, 8'hA0 + 8'(a)});

    // Simultaneous starts: save wins; a load request while busy is ignored
    ack_delay = 0;
    key = 8'($urandom);
    fork
      run(1'b1, 1'b1);
      begin
        repeat (40) @(negedge clk);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
      end
    join

    // Ack withheld for 100+ cycles on slot 5
    stall_addr = 5;
    fork
      run(1'b1, 1'b0);
      begin
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
          @(negedge clk);
          #1;
          found = bus.mem_req && (bus.mem_addr == 16'd5);
        end
        repeat (100) @(negedge clk);
        #1;
        check("stall_req_held", bus.mem_req, 1);
        check("stall_mem_addr", bus.mem_addr, 5);
        check("stall_sst_addr_lit", bus.sst_addr, 5);
      end
    join
    stall_addr = -1;

    // Load of random buffer contents with random ack latency
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    run(1'b0, 1'b0);

    // Reset during a load HOLD at slot 40
    @(negedge clk);
    exp_save = 1'b0;
    exp_idx = 0;
    chk_en = 1'b1;
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10000 && !found; i++) begin
      @(negedge clk);
      #1;
      found = bus.sst_we_reg && (bus.sst_addr == 8'd40);
    end
    check("reached_slot40_hold", found, 1);
    d0 = done_cnt;
    rst = 1'b1;
    chk_en = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_act", bus.sst_act, 0);
    check("midrst_we_reg", bus.sst_we_reg, 0);
    check("midrst_mem_req", bus.mem_req, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    check("no_done_after_rst", done_cnt, d0);
    check("midrst_idle", busy, 0);

`ifdef SST_CHECKSUM_EN
    // Checksum: save, corrupt slot 10, load (mismatch), restore, load (clean)
    key = 8'h5A;
    run(1'b1, 1'b0);
    mem[10] = mem[10] + 8'd1;
    run(1'b0, 1'b0);
    check("sum_err_corrupt", sum_err, 1);
    mem[10] = mem[10] - 8'd1;
    run(1'b0, 1'b0);
    check("sum_err_clean", sum_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
